// File: rtl/apb_req_master.sv
// apb_req_master: turns a valid/ready request channel into single APB transfers, one outstanding.
// Optional ACCESS-phase timeout is built when APB_REQ_MASTER_TIMEOUT_EN is defined.
module apb_req_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  req_write_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [STRB_WIDTH-1:0] req_strb_i,
   input  logic [2:0]            req_prot_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [2:0]            pprot_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   output logic [STRB_WIDTH-1:0] pstrb_o,
   input  logic                  pready_i,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pslverr_i
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state;

   if ((DATA_WIDTH % 8) != 0 || STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_width
      $error("apb_req_master: DATA_WIDTH must be a multiple of 8 and STRB_WIDTH = DATA_WIDTH/8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_req_master: TIMEOUT_CYCLES must be at least 1");
   end

   // NOTE: a continuous decode of the state register has no storage path, so it cannot infer a latch.
   assign req_ready_o = (state == IDLE);

`ifdef APB_REQ_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

   // Counts completed ACCESS cycles; equals LAST_CYCLE during the final allowed one.
   logic [CNT_W-1:0] access_cnt;
   logic             timeout;

   assign timeout = (access_cnt == LAST_CYCLE);
`endif

   // NOTE: every register here uses non-blocking assignment so all state updates on one edge see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         paddr_o     <= '0;
         pwdata_o    <= '0;
         pstrb_o     <= '0;
         pprot_o     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
         access_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  paddr_o   <= req_addr_i;
                  pwrite_o  <= req_write_i;
                  pprot_o   <= req_prot_i;
                  pwdata_o  <= req_write_i ? req_wdata_i : '0;
                  pstrb_o   <= req_write_i ? req_strb_i : '0;
                  psel_o    <= 1'b1;
                  penable_o <= 1'b0;
                  state     <= SETUP;
               end
            end

            SETUP: begin
               penable_o <= 1'b1;
               state     <= ACCESS;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
               access_cnt <= '0;
`endif
            end

            ACCESS: begin
               // A ready slave wins over an expiring timeout in the same cycle.
               if (pready_i) begin
                  rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                  rsp_err_o   <= pslverr_i;
                  rsp_valid_o <= 1'b1;
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  state       <= RESP;
               end
`ifdef APB_REQ_MASTER_TIMEOUT_EN
               else if (timeout) begin
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  state       <= RESP;
               end else begin
                  access_cnt <= access_cnt + 1'b1;
               end
`endif
            end

            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
